mult_div_unit: RTL

- Iterative integer multiply/divide unit in the EX stage, directly downstream of the register file. It consumes ReadData1/ReadData2 as operands A/B for MULT, MULTU, DIV and DIVU, and holds the results in architectural HI/LO registers.
- HI/LO are read by MFHI/MFLO and written by MTHI/MTLO.
- The pipeline stalls on Busy.

---
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One step per cycle for WIDTH cycles; Busy stalls the pipeline, Done pulses when HI/LO hold the result.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] MoveData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } stateT;

    stateT state, stateNext;

    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accStep;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   origA;
    logic               isDiv;
    logic               negResult;
    logic               negRemainder;
    logic               divZero;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;

    logic               signedOp;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    assign Busy = (state == CALC);
    assign Done = (state == FINISH);
    assign HI   = hiReg;
    assign LO   = loReg;

    always_comb begin
        signedOp = ~Op[0];
        absA     = (signedOp && A[WIDTH-1]) ? -A : A;
        absB     = (signedOp && B[WIDTH-1]) ? -B : B;
    end

    // Multiply keeps the multiplier in the low half of acc; divide keeps {remainder, quotient} there.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divDiff  = divShift - {1'b0, operand};
        accStep  = {mulSum, acc[WIDTH-1:1]};
        if (isDiv) begin
            if (!divDiff[WIDTH]) begin
                accStep = {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                accStep = {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        product = negResult ? -accStep : accStep;
        quot    = accStep[WIDTH-1:0];
        rem     = accStep[2*WIDTH-1:WIDTH];
        resHi   = product[2*WIDTH-1:WIDTH];
        resLo   = product[WIDTH-1:0];
        if (isDiv) begin
            if (divZero) begin
                resHi = origA;
                resLo = '1;
            end else begin
                resHi = negRemainder ? -rem : rem;
                resLo = negResult ? -quot : quot;
            end
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, FINISH: stateNext = Start ? CALC : IDLE;
            CALC:         if (counter == LastStep) stateNext = FINISH;
            default:      stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Moves are only honoured outside CALC, so they never collide with the final result load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            counter      <= '0;
            acc          <= '0;
            operand      <= '0;
            origA        <= '0;
            isDiv        <= 1'b0;
            negResult    <= 1'b0;
            negRemainder <= 1'b0;
            divZero      <= 1'b0;
            hiReg        <= '0;
            loReg        <= '0;
        end else if (state != CALC) begin
            if (HiWrite) hiReg <= MoveData;
            if (LoWrite) loReg <= MoveData;
            if (Start) begin
                counter      <= '0;
                isDiv        <= Op[1];
                origA        <= A;
                negResult    <= signedOp & (A[WIDTH-1] ^ B[WIDTH-1]);
                negRemainder <= signedOp & Op[1] & A[WIDTH-1];
                divZero      <= Op[1] & (B == '0);
                if (Op[1]) begin
                    acc     <= {{WIDTH{1'b0}}, absA};
                    operand <= absB;
                end else begin
                    acc     <= {{WIDTH{1'b0}}, absB};
                    operand <= absA;
                end
            end
        end else begin
            acc     <= accStep;
            counter <= counter + CW'(1);
            if (counter == LastStep) begin
                hiReg <= resHi;
                loReg <= resLo;
            end
        end
    end

endmodule
